// File: rtl/lenet5_feeder_pkg.sv
// rtl/lenet5_feeder_pkg.sv - shared FSM encoding, result codes and frame sizing helpers
package lenet5_feeder_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [3:0] TIMEOUT_CODE = 4'hF;

  function automatic int npix_of(input int if_size);
    return if_size * if_size;
  endfunction

  function automatic int cnt_width(input int npix);
    return (npix > 1) ? $clog2(npix) : 1;
  endfunction

endpackage

// File: rtl/lenet5_feeder_pixel_deserializer.sv
// rtl/lenet5_feeder_pixel_deserializer.sv - row-major pixel stream to flat frame register
// Owns the pixel counter, i_sof resync and the frame storage; pulses frame_done on the last pixel.
module pixel_deserializer #(
  parameter int I_BW = 8,
  parameter int NPIX = 784,
  parameter int CW   = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clear,
  input  logic                   valid,
  input  logic                   sof,
  input  logic [I_BW-1:0]        pixel,
  output logic [NPIX*I_BW-1:0]   fmap,
  output logic                   frame_done
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] widx;
  logic          accept;
  logic          last;

  assign accept     = en & valid;
  assign widx       = sof ? '0 : cnt;
  assign last       = (cnt == CW'(NPIX - 1));
  assign frame_done = accept & ~sof & last;

  // wrap to 0 on the final pixel so cnt never reaches NPIX
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (accept) begin
      if (sof)
        cnt <= CW'(1);
      else if (last)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      fmap <= '0;
    else if (accept)
      fmap[int'(widx)*I_BW +: I_BW] <= pixel;
  end

endmodule

// File: rtl/lenet5_feeder.sv
// rtl/lenet5_feeder.sv - frame loader and result port for the LeNet-5 classifier
// Optional watchdog on RUN is enabled with the FEEDER_TIMEOUT_EN macro.
module lenet5_feeder
  import lenet5_feeder_pkg::*;
#(
  parameter int I_BW    = 8,
  parameter int IF_SIZE = 28,
  parameter int TIMEOUT = 4096
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_valid,
  input  logic                            i_sof,
  input  logic [I_BW-1:0]                 i_pixel,
  output logic                            o_ready,
  output logic [IF_SIZE*IF_SIZE*I_BW-1:0] o_fmap,
  output logic                            o_ce,
  input  logic                            i_end,
  input  logic [3:0]                      i_result,
  output logic                            o_result_valid,
  output logic [3:0]                      o_result,
  input  logic                            i_result_ready,
  output logic                            o_busy,
  output logic                            o_err
);

  localparam int NPIX = npix_of(IF_SIZE);
  localparam int CW   = cnt_width(NPIX);

  state_t     state;
  state_t     state_nx;
  logic       frame_done;
  logic       handshake;
  logic       wd_hit;
  logic [3:0] result_q;

  assign handshake = (state == ST_HOLD) & i_result_ready;

  pixel_deserializer #(
    .I_BW (I_BW),
    .NPIX (NPIX),
    .CW   (CW)
  ) u_deser (
    .clk        (clk),
    .rst        (rst),
    .en         (state == ST_LOAD),
    .clear      (handshake),
    .valid      (i_valid),
    .sof        (i_sof),
    .pixel      (i_pixel),
    .fmap       (o_fmap),
    .frame_done (frame_done)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_LOAD;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_LOAD: if (frame_done) state_nx = ST_RUN;
      ST_RUN:  if (i_end || wd_hit) state_nx = ST_HOLD;
      ST_HOLD: if (i_result_ready) state_nx = ST_LOAD;
      default: state_nx = ST_LOAD;
    endcase
  end

  always_comb begin
    o_ready        = (state == ST_LOAD);
    o_ce           = (state == ST_RUN);
    o_result_valid = (state == ST_HOLD);
    o_busy         = (state == ST_RUN) || (state == ST_HOLD);
    o_result       = result_q;
  end

`ifdef FEEDER_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [WD_W-1:0] wdog;
  logic            err_q;

  assign wd_hit = (state == ST_RUN) && (wdog == WD_W'(TIMEOUT - 1));
  assign o_err  = err_q & (state == ST_HOLD);

  always_ff @(posedge clk) begin
    if (rst || frame_done)
      wdog <= '0;
    else if (state == ST_RUN)
      wdog <= wdog + 1'b1;
  end

  // a done pulse on the limit cycle takes priority over the timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      err_q    <= 1'b0;
    end else if (state == ST_RUN) begin
      if (i_end) begin
        result_q <= i_result;
        err_q    <= 1'b0;
      end else if (wd_hit) begin
        result_q <= TIMEOUT_CODE;
        err_q    <= 1'b1;
      end
    end
  end
`else
  assign wd_hit = 1'b0;
  assign o_err  = 1'b0;

  always_ff @(posedge clk) begin
    if (rst)
      result_q <= '0;
    else if ((state == ST_RUN) && i_end)
      result_q <= i_result;
  end
`endif

endmodule

// File: tb/tb_lenet5_feeder.sv
// tb/tb_lenet5_feeder.sv - randomized self-checking bench for lenet5_feeder against a frame model
module tb_lenet5_feeder;

  localparam int I_BW    = 8;
  localparam int IF_SIZE = 28;
  localparam int NPIX    = IF_SIZE * IF_SIZE;
`ifdef FEEDER_TIMEOUT_EN
  localparam int TIMEOUT  = 16;
  localparam int RUN_WAIT = 5;
`else
  localparam int TIMEOUT  = 4096;
  localparam int RUN_WAIT = 50;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   i_valid = 1'b0;
  logic                   i_sof = 1'b0;
  logic [I_BW-1:0]        i_pixel = '0;
  logic                   o_ready;
  logic [NPIX*I_BW-1:0]   o_fmap;
  logic                   o_ce;
  logic                   i_end = 1'b0;
  logic [3:0]             i_result = '0;
  logic                   o_result_valid;
  logic [3:0]             o_result;
  logic                   i_result_ready = 1'b0;
  logic                   o_busy;
  logic                   o_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_mem[NPIX];
  int         pos;
  logic [7:0] pix_q[$];
  bit         sof_q[$];

  lenet5_feeder #(.I_BW(I_BW), .IF_SIZE(IF_SIZE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_sof(i_sof), .i_pixel(i_pixel),
    .o_ready(o_ready), .o_fmap(o_fmap), .o_ce(o_ce), .i_end(i_end), .i_result(i_result),
    .o_result_valid(o_result_valid), .o_result(o_result), .i_result_ready(i_result_ready),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int k = 0; k < NPIX; k++) exp_mem[k] = 8'h00;
    pos = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_clear();
  endtask

  task automatic make_frame(input int n, input bit random_data);
    for (int k = 0; k < n; k++) begin
      pix_q.push_back(random_data ? 8'($urandom) : 8'(k % 256));
      sof_q.push_back(k == 0);
    end
  endtask

  // Streams the queued pixels; the model predicts where each lands and when the frame completes.
  task automatic send_pixels(input int gap_pct, input bit end_noise,
                             output int ready_bad, output int ce_bad, output int load_bad);
    int  idx;
    bit  run;
    ready_bad = 0; ce_bad = 0; load_bad = 0;
    for (int i = 0; i < pix_q.size(); i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        i_valid  = 1'b0;
        i_end    = end_noise ? 1'($urandom_range(1)) : 1'b0;
        i_result = 4'($urandom);
        step();
        i_end = 1'b0;
        if (o_ready !== 1'b1 || o_result_valid !== 1'b0 || o_ce !== 1'b0) load_bad++;
      end
      i_valid = 1'b1;
      i_sof   = sof_q[i];
      i_pixel = pix_q[i];
      if (o_ready !== 1'b1) ready_bad++;
      idx = sof_q[i] ? 0 : pos;
      exp_mem[idx] = pix_q[i];
      run = !sof_q[i] && (idx == NPIX - 1);
      pos = run ? 0 : idx + 1;
      step();
      i_valid = 1'b0;
      i_sof   = 1'b0;
      if (o_ce !== run) ce_bad++;
    end
    pix_q.delete();
    sof_q.delete();
  endtask

  task automatic count_fmap_bad(output int nbad, output int first);
    nbad = 0; first = -1;
    for (int k = 0; k < NPIX; k++)
      if (o_fmap[k*I_BW +: I_BW] !== exp_mem[k]) begin
        if (first < 0) first = k;
        nbad++;
      end
  endtask

  task automatic do_result(input logic [3:0] r, output logic [3:0] got, output logic v, output logic e);
    i_end = 1'b1; i_result = r;
    step();
    i_end = 1'b0; i_result = 4'($urandom);
    got = o_result; v = o_result_valid; e = o_err;
    i_result_ready = 1'b1;
    step();
    i_result_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    total++; if (o_ce !== 1'b0) begin bad++; $display("FAIL reset_ce: got %b want 0", o_ce); end
    total++; if (o_result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", o_result_valid); end
    total++; if (o_result !== 4'h0) begin bad++; $display("FAIL reset_result: got %h want 0", o_result); end
    total++; if (o_busy !== 1'b0 || o_err !== 1'b0) begin bad++; $display("FAIL reset_busy_err: got %b%b want 00", o_busy, o_err); end
    total++; if (o_fmap !== '0) begin bad++; $display("FAIL reset_fmap: got nonzero want 0"); end
  endtask

  task automatic test_ramp();
    int rb, cb, lb, nb, fi;
    make_frame(NPIX, 1'b0);
    send_pixels(0, 1'b0, rb, cb, lb);
    total++; if (rb != 0) begin bad++; $display("FAIL ramp_ready: got %0d stalls want 0", rb); end
    total++; if (cb != 0) begin bad++; $display("FAIL ramp_ce_timing: got %0d wrong cycles want 0", cb); end
    count_fmap_bad(nb, fi);
    total++; if (nb != 0) begin bad++; $display("FAIL ramp_fmap: got %0d bad pixels (first %0d) want 0", nb, fi); end
    total++; if (o_busy !== 1'b1 || o_ready !== 1'b0) begin bad++; $display("FAIL ramp_run_flags: got busy=%b ready=%b want 1 0", o_busy, o_ready); end
  endtask

  task automatic test_result_return();
    int nb, fi, rb, hb;
    rb = 0; hb = 0;
    for (int c = 0; c < RUN_WAIT; c++) begin
      i_valid = 1'b1; i_sof = 1'($urandom_range(1)); i_pixel = 8'($urandom);
      step();
      if (o_ce !== 1'b1 || o_ready !== 1'b0 || o_result_valid !== 1'b0) rb++;
    end
    i_valid = 1'b0; i_sof = 1'b0;
    total++; if (rb != 0) begin bad++; $display("FAIL run_hold_ce: got %0d bad cycles want 0", rb); end
    count_fmap_bad(nb, fi);
    total++; if (nb != 0) begin bad++; $display("FAIL run_fmap_frozen: got %0d changed (first %0d) want 0", nb, fi); end
    i_end = 1'b1; i_result = 4'd7;
    step();
    i_end = 1'b0;
    for (int c = 0; c < 5; c++) begin
      i_result = 4'($urandom);
      if (o_result_valid !== 1'b1 || o_result !== 4'd7 || o_ce !== 1'b0 || o_err !== 1'b0 || o_ready !== 1'b0) hb++;
      if (c < 4) step();
    end
    total++; if (hb != 0) begin bad++; $display("FAIL result_held: got %0d bad cycles want 0 (last result %h)", hb, o_result); end
    i_result_ready = 1'b1;
    step();
    i_result_ready = 1'b0;
    total++; if (o_ready !== 1'b1 || o_result_valid !== 1'b0 || o_busy !== 1'b0) begin bad++; $display("FAIL result_handshake: got ready=%b valid=%b busy=%b want 1 0 0", o_ready, o_result_valid, o_busy); end
  endtask

  task automatic test_back_to_back();
    int rb, cb, lb, nb, fi;
    logic [3:0] r;
    i_result_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      make_frame(NPIX, 1'b1);
      send_pixels(0, 1'b0, rb, cb, lb);
      total++; if (rb != 0 || cb != 0) begin bad++; $display("FAIL b2b_load: got ready_bad=%0d ce_bad=%0d want 0 0", rb, cb); end
      count_fmap_bad(nb, fi);
      total++; if (nb != 0) begin bad++; $display("FAIL b2b_fmap: got %0d bad pixels (first %0d) want 0", nb, fi); end
      r = 4'($urandom_range(9));
      i_end = 1'b1; i_result = r;
      step();
      i_end = 1'b0;
      total++; if (o_result_valid !== 1'b1 || o_result !== r) begin bad++; $display("FAIL b2b_result: got valid=%b result=%h want 1 %h", o_result_valid, o_result, r); end
      step();
      total++; if (o_ready !== 1'b1 || o_result_valid !== 1'b0) begin bad++; $display("FAIL b2b_hold_one: got ready=%b valid=%b want 1 0", o_ready, o_result_valid); end
    end
    i_result_ready = 1'b0;
  endtask

  task automatic test_resync();
    int rb, cb, lb, nb, fi;
    logic [7:0] first2;
    logic [3:0] r, got;
    logic v, e;
    make_frame(100, 1'b1);
    make_frame(NPIX, 1'b1);
    first2 = pix_q[100];
    send_pixels(0, 1'b0, rb, cb, lb);
    total++; if (cb != 0) begin bad++; $display("FAIL resync_run_entry: got %0d wrong cycles want 0", cb); end
    total++; if (o_fmap[I_BW-1:0] !== first2) begin bad++; $display("FAIL resync_pixel0: got %h want %h", o_fmap[I_BW-1:0], first2); end
    count_fmap_bad(nb, fi);
    total++; if (nb != 0) begin bad++; $display("FAIL resync_fmap: got %0d bad pixels (first %0d) want 0", nb, fi); end
    r = 4'($urandom_range(9));
    do_result(r, got, v, e);
    total++; if (v !== 1'b1 || got !== r || e !== 1'b0) begin bad++; $display("FAIL resync_result: got v=%b r=%h e=%b want 1 %h 0", v, got, e, r); end
  endtask

  task automatic test_gapped();
    int rb, cb, lb, nb, fi;
    logic [NPIX*I_BW-1:0] snap;
    logic [7:0] data[$];
    logic [3:0] got;
    logic v, e;
    for (int k = 0; k < NPIX; k++) data.push_back(8'($urandom));
    for (int k = 0; k < NPIX; k++) begin pix_q.push_back(data[k]); sof_q.push_back(k == 0); end
    send_pixels(0, 1'b0, rb, cb, lb);
    snap = o_fmap;
    do_result(4'd3, got, v, e);
    for (int k = 0; k < NPIX; k++) begin pix_q.push_back(data[k]); sof_q.push_back(k == 0); end
    send_pixels(30, 1'b1, rb, cb, lb);
    total++; if (lb != 0) begin bad++; $display("FAIL gapped_end_ignored: got %0d bad idle cycles want 0", lb); end
    total++; if (cb != 0 || rb != 0) begin bad++; $display("FAIL gapped_flow: got ce_bad=%0d ready_bad=%0d want 0 0", cb, rb); end
    total++; if (o_fmap !== snap) begin bad++; $display("FAIL gapped_vs_ungapped: got differing frame want identical"); end
    count_fmap_bad(nb, fi);
    total++; if (nb != 0) begin bad++; $display("FAIL gapped_fmap: got %0d bad pixels (first %0d) want 0", nb, fi); end
    do_result(4'd9, got, v, e);
    total++; if (v !== 1'b1 || got !== 4'd9) begin bad++; $display("FAIL gapped_result: got v=%b r=%h want 1 9", v, got); end
  endtask

  task automatic test_reset_mid_run();
    int rb, cb, lb, sb;
    make_frame(NPIX, 1'b1);
    send_pixels(0, 1'b0, rb, cb, lb);
    step(); step(); step();
    apply_reset();
    total++; if (o_ce !== 1'b0 || o_result_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin bad++; $display("FAIL rst_run_flags: got ce=%b valid=%b ready=%b busy=%b want 0 0 1 0", o_ce, o_result_valid, o_ready, o_busy); end
    total++; if (o_fmap !== '0) begin bad++; $display("FAIL rst_run_fmap: got nonzero want 0"); end
    i_end = 1'b1; i_result = 4'd5;
    step();
    i_end = 1'b0;
    sb = 0;
    for (int c = 0; c < 5; c++) begin
      if (o_result_valid !== 1'b0 || o_ready !== 1'b1 || o_result !== 4'd0) sb++;
      step();
    end
    total++; if (sb != 0) begin bad++; $display("FAIL rst_late_end: got %0d bad cycles want 0", sb); end
  endtask

`ifdef FEEDER_TIMEOUT_EN
  task automatic test_timeout();
    int rb, cb, lb, eb;
    logic [3:0] r;
    make_frame(NPIX, 1'b1);
    send_pixels(0, 1'b0, rb, cb, lb);
    eb = 0;
    for (int c = 1; c < TIMEOUT; c++) begin
      step();
      if (o_result_valid !== 1'b0 || o_ce !== 1'b1) eb++;
    end
    total++; if (eb != 0) begin bad++; $display("FAIL timeout_early: got %0d early cycles want 0", eb); end
    step();
    total++; if (o_result_valid !== 1'b1 || o_result !== 4'hF || o_err !== 1'b1) begin bad++; $display("FAIL timeout_fire: got v=%b r=%h e=%b want 1 f 1", o_result_valid, o_result, o_err); end
    i_result_ready = 1'b1; step(); i_result_ready = 1'b0;
    make_frame(NPIX, 1'b1);
    send_pixels(0, 1'b0, rb, cb, lb);
    for (int c = 1; c < TIMEOUT; c++) step();
    r = 4'($urandom_range(9));
    i_end = 1'b1; i_result = r;
    step();
    i_end = 1'b0;
    total++; if (o_result_valid !== 1'b1 || o_result !== r || o_err !== 1'b0) begin bad++; $display("FAIL timeout_end_wins: got v=%b r=%h e=%b want 1 %h 0", o_result_valid, o_result, o_err, r); end
    i_result_ready = 1'b1; step(); i_result_ready = 1'b0;
  endtask
`endif

  initial begin
    model_clear();
    test_reset();
    test_ramp();
    test_result_return();
    test_back_to_back();
    test_resync();
    test_gapped();
    test_reset_mid_run();
`ifdef FEEDER_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
